sim_ctrl: RTL

SIM_CTRL -- requirements
Module: sim_ctrl

---
 rtl/sim_ctrl_pkg.sv | 54 +++++
 rtl/sim_ctrl_fifo.sv | 54 +++++
 rtl/sim_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: register map, STATUS bit layout and small helpers shared by
// the sim_ctrl control block and its console FIFO.
package sim_ctrl_pkg;

  // Word offsets, decoded from addr[4:2]
  localparam logic [2:0] OFS_CTRL    = 3'd0;
  localparam logic [2:0] OFS_TESTNUM = 3'd1;
  localparam logic [2:0] OFS_CONSOLE = 3'd2;
  localparam logic [2:0] OFS_STATUS  = 3'd3;
  localparam logic [2:0] OFS_TIMEOUT = 3'd4;
  localparam logic [2:0] OFS_CYCLES  = 3'd5;

  // STATUS bit positions
  localparam int unsigned STAT_EMPTY    = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_LVL_LSB  = 2;
  localparam int unsigned STAT_SIM_END  = 10;
  localparam int unsigned STAT_SIM_SUCC = 11;

  // TESTNUM value loaded when the watchdog ends the test
  localparam logic [31:0] TIMEOUT_TESTNUM = 32'hFFFF_FFFF;

  // Saturation value of the free-running cycle counter
  localparam logic [31:0] CYCLES_MAX = 32'hFFFF_FFFF;

  // Merge a write into a register, one byte lane per byte enable.
  function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

  // Assemble the STATUS word from its fields.
  function automatic logic [31:0] pack_status(input logic       succ,
                                              input logic       sim_end,
                                              input logic [7:0] level,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] s;
    s = '0;
    s[STAT_EMPTY]            = empty;
    s[STAT_FULL]             = full;
    s[STAT_LVL_LSB +: 8]     = level;
    s[STAT_SIM_END]          = sim_end;
    s[STAT_SIM_SUCC]         = succ;
    return s;
  endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// sim_ctrl_fifo: byte FIFO for the console stream. Power-of-two depth,
// read and write pointers carry one extra MSB so full and empty are told
// apart without a separate counter.
module sim_ctrl_fifo
  import sim_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is only accepted when a pop frees a slot
  // in the same cycle, so the level stays unchanged.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update; wrap-around comes from natural overflow of AW+1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset because empty gates the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation control block on a req/gnt/rvalid bus. Holds the
// test end/pass flags, the failing test number, a watchdog against a
// free-running cycle counter and an optional console byte stream.
// The console FIFO is built only when SIM_CTRL_CONSOLE_EN is defined;
// otherwise CONSOLE writes are accepted and dropped.
//
// Bus handshake: a request is accepted in the cycle where req_i && gnt_o.
// gnt_o is combinational from req_i and is held low only for a CONSOLE
// write while the FIFO is full. Every accepted request produces exactly one
// rvalid_o pulse on the following cycle; data_o carries the read value for
// reads and 0 for writes. CTRL reads back {sim_succ, sim_end}; CONSOLE,
// and unmapped offsets, read 0.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int          CONSOLE_DEPTH = 8,
  parameter logic [31:0] TIMEOUT_RST   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] data_o,
  output logic        sim_end_o,
  output logic        sim_succ_o,
  output logic [31:0] fail_num_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i
);

  logic [2:0]  idx;
  logic        con_full;
  logic        con_empty;
  logic [7:0]  con_level;
  logic        accept;
  logic        wr;
  logic        ctrl_end;
  logic        tmo_end;
  logic [31:0] rdata;

  logic        rvalid_q;
  logic [31:0] data_q;
  logic        sim_end_q;
  logic        sim_succ_q;
  logic [31:0] testnum_q;
  logic [31:0] timeout_q;
  logic [31:0] cycles_q;

  assign idx    = addr_i[4:2];
  assign gnt_o  = req_i && !(we_i && (idx == OFS_CONSOLE) && con_full);
  assign accept = req_i && gnt_o;
  assign wr     = accept && we_i;

  // First end event wins; a CTRL end write beats a watchdog hit in the
  // same cycle, so the watchdog only fires when no CTRL end is happening.
  assign ctrl_end = wr && (idx == OFS_CTRL) && be_i[0] && data_i[0] && !sim_end_q;
  assign tmo_end  = (timeout_q != '0) && !sim_end_q && (cycles_q == timeout_q) && !ctrl_end;

`ifdef SIM_CTRL_CONSOLE_EN
  logic                            con_push;
  logic                            con_pop;
  logic [7:0]                      con_head;
  logic [$clog2(CONSOLE_DEPTH):0]  fifo_level;
  logic                            unused_bits;

  assign con_push = wr && (idx == OFS_CONSOLE) && be_i[0];
  assign con_pop  = char_valid_o && char_ready_i;

  sim_ctrl_fifo #(
    .DEPTH (CONSOLE_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (con_push),
    .wdata (data_i[7:0]),
    .pop   (con_pop),
    .rdata (con_head),
    .empty (con_empty),
    .full  (con_full),
    .level (fifo_level)
  );

  assign con_level    = 8'(fifo_level);
  assign char_valid_o = !con_empty;
  assign char_data_o  = con_head;
  assign unused_bits  = ^{addr_i[31:5], addr_i[1:0]};
`else
  logic unused_bits;

  assign con_full     = 1'b0;
  assign con_empty    = 1'b1;
  assign con_level    = 8'd0;
  assign char_valid_o = 1'b0;
  assign char_data_o  = 8'd0;
  assign unused_bits  = ^{addr_i[31:5], addr_i[1:0], char_ready_i};
`endif

  // Read multiplexer over the register map.
  always_comb begin
    rdata = '0;
    case (idx)
      OFS_CTRL:    rdata = {30'd0, sim_succ_q, sim_end_q};
      OFS_TESTNUM: rdata = testnum_q;
      OFS_STATUS:  rdata = pack_status(sim_succ_q, sim_end_q, con_level, con_full, con_empty);
      OFS_TIMEOUT: rdata = timeout_q;
      OFS_CYCLES:  rdata = cycles_q;
      default:     rdata = '0;
    endcase
  end

  // Response stage: one rvalid pulse per accepted request; reset drops it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      data_q   <= '0;
    end else begin
      rvalid_q <= accept;
      data_q   <= (accept && !we_i) ? rdata : '0;
    end
  end

  // Sticky end/pass flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sim_end_q  <= 1'b0;
      sim_succ_q <= 1'b0;
    end else if (ctrl_end) begin
      sim_end_q  <= 1'b1;
      sim_succ_q <= data_i[1];
    end else if (tmo_end) begin
      sim_end_q  <= 1'b1;
      sim_succ_q <= 1'b0;
    end
  end

  // TESTNUM: byte-lane writes, overwritten by the watchdog marker on timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      testnum_q <= '0;
    end else if (tmo_end) begin
      testnum_q <= TIMEOUT_TESTNUM;
    end else if (wr && (idx == OFS_TESTNUM)) begin
      testnum_q <= apply_be(testnum_q, data_i, be_i);
    end
  end

  // TIMEOUT: byte-lane writes; zero leaves the watchdog off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= TIMEOUT_RST;
    end else if (wr && (idx == OFS_TIMEOUT)) begin
      timeout_q <= apply_be(timeout_q, data_i, be_i);
    end
  end

  // Free-running cycle counter, saturating at all ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (cycles_q != CYCLES_MAX) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign rvalid_o   = rvalid_q;
  assign data_o     = data_q;
  assign sim_end_o  = sim_end_q;
  assign sim_succ_o = sim_succ_q;
  assign fail_num_o = testnum_q;

endmodule
